// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches words over a variable-latency
// req/ack port and buffers up to two {word, pc} entries for decode.
//
// Handshakes:
//   imem   : imem_req and imem_addr rise together and stay steady until a
//            cycle with imem_ack=1, which also carries imem_rdata. A req-high
//            cycle after an ack cycle is a new request. Reset may drop req
//            without an ack.
//   decode : an entry transfers in any cycle with instr_valid=1 and stall=0.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic        instr_valid,
   output logic [31:0] instruction,
   output logic [31:0] instr_pc,
   output logic [1:0]  fetch_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

   state_t      state, state_n;
   logic [31:0] pc, pc_n;
   logic [31:0] req_addr, req_addr_n;

   // Two-slot circular buffer; rd_ptr selects the head entry.
   logic [31:0] word_q [2];
   logic [31:0] pc_q   [2];
   logic        rd_ptr;
   logic [1:0]  count;
   logic        wr_ptr;

   logic        consume;
   logic        push;
   logic [1:0]  cnt_after_pop;
   logic [1:0]  cnt_after_push;
   logic        space;
   logic [31:0] pc_plus4;
   logic [31:0] redirect_aligned;

   assign instr_valid      = (count != 2'd0) & ~redirect;
   assign consume          = instr_valid & ~stall;
   assign cnt_after_pop    = count - {1'b0, consume};
   assign cnt_after_push   = cnt_after_pop + 2'd1;
   assign space            = cnt_after_pop < DEPTH;
   assign pc_plus4         = pc + 32'd4;
   assign redirect_aligned = {redirect_pc[31:2], 2'b00};
   // With count 2 the write slot is the head being popped, which is exactly
   // the slot freed in that cycle.
   assign wr_ptr           = rd_ptr ^ count[0];

   assign imem_req    = (state != IDLE);
   assign imem_addr   = req_addr;
   assign instruction = word_q[rd_ptr];
   assign instr_pc    = pc_q[rd_ptr];
   assign fetch_state = state;

   // FSM state, PC and request address registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         req_addr <= RESET_PC;
      end else begin
         state    <= state_n;
         pc       <= pc_n;
         req_addr <= req_addr_n;
      end
   end

   // Next-state logic; redirect outranks ack, which outranks consume.
   always_comb begin
      state_n    = state;
      pc_n       = pc;
      req_addr_n = req_addr;
      push       = 1'b0;
      case (state)
         IDLE: begin
            if (redirect) begin
               pc_n = redirect_aligned;
            end else if (space) begin
               req_addr_n = pc;
               state_n    = WAIT;
            end
         end
         WAIT: begin
            if (redirect) begin
               // A response arriving with the redirect is dropped here; an
               // outstanding one is drained and dropped in DRAIN.
               pc_n    = redirect_aligned;
               state_n = imem_ack ? IDLE : DRAIN;
            end else if (imem_ack) begin
               push = 1'b1;
               pc_n = pc_plus4;
               if (cnt_after_push < DEPTH) begin
                  req_addr_n = pc_plus4;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         DRAIN: begin
            if (redirect) begin
               pc_n = redirect_aligned;
            end
            if (imem_ack) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Fetch buffer: any redirect flushes it, since buffered words belong to
   // the abandoned path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count  <= 2'd0;
         rd_ptr <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            word_q[i] <= 32'd0;
            pc_q[i]   <= 32'd0;
         end
      end else if (redirect) begin
         count  <= 2'd0;
         rd_ptr <= 1'b0;
      end else begin
         if (push) begin
            word_q[wr_ptr] <= imem_rdata;
            pc_q[wr_ptr]   <= req_addr;
         end
         if (consume) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= cnt_after_pop + {1'b0, push};
      end
   end

   // In WAIT one word is outstanding, so the buffer must hold at most one.
   a_no_overcommit: assert property (
      @(posedge clk) disable iff (!rst_n) (state == WAIT) |-> (count < DEPTH)
   );

endmodule
